serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. Computes D = A - B - Bin, one bit per clock, LSB first, using a registered borrow.
- Counterpart to the team's combinational 4-bit adder: same operand and carry interface, opposite arithmetic direction.
- Start/done handshake so a control FSM or testbench can sequence operations.
- Default width matches the existing 4-bit datapath.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on accepted start.
- B  input  WIDTH  subtrahend; captured on accepted start.
- Bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high from accept through the DONE cycle.
- done  output  1  one-cycle pulse; result valid.
- D  output  WIDTH  difference; held until the next accepted start.
- Bout  output  1  borrow-out (1 when A < B + Bin, unsigned).

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; busy=0, done=0, D=0, Bout=0.
  - Internal shift registers, borrow and bit counter all cleared.
- States:
  - IDLE: on start=1 at edge k, latch A, B and Bin; borrow<=Bin; cnt<=0; go to SHIFT. busy=1 from edge k.
  - SHIFT: each edge computes one bit i=cnt from the LSBs of the shifted A/B copies.
    - d_i = a^b^borrow.
    - borrow <= (~a&b) | (~(a^b)&borrow).
    - d_i shifts into the result register from the MSB side; cnt increments.
    - After WIDTH edges (edges k+1..k+WIDTH), load D and Bout and go to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle. Next edge returns to IDLE; busy=0, done=0.
- Latency: accept at edge k; done high during the cycle after edge k+WIDTH. Back-to-back start accepted at edge k+WIDTH+2 at the earliest.
- start while busy (SHIFT or DONE): ignored; no queuing.
- A, B and Bin may change freely after accept; internal copies are used.
- D and Bout only update at the SHIFT->DONE transition; intermediate bits are never visible on D.
- Counter width is $clog2(WIDTH+1). No wrap: cnt never exceeds WIDTH.
- reset_n asserted mid-SHIFT: operation aborted, outputs cleared, no done pulse.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - Adds output ovf (1 bit): signed two's-complement overflow of A - B - Bin.
  - ovf = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), evaluated on the captured operands.
  - Updated with D; reset 0.
- When undefined: port and logic are absent; behaviour otherwise identical.

Decomposition:
- Shared package serial_sub_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Default WIDTH constant.
- Sub-module full_subtractor_bit: combinational 1-bit a, b, bin -> d, bout.
  - Instantiated once, in the SHIFT datapath.
  - Reusable by a later ripple subtractor.

Test Plan:
- Reset, then idle 100 ns with start=0 -> busy=0, done=0, D=0000, Bout=0.
- A=0101, B=1010, Bin=0, start pulse -> done exactly 5 cycles after accept (WIDTH=4); D=1011, Bout=1.
- A=0000, B=0001, Bin=0 -> D=1111, Bout=1. Then A=0110, B=0001, Bin=0 -> D=0101, Bout=0.
- A=0000, B=1111, Bin=1 -> D=0000, Bout=1. Also hold start=1 continuously: one done pulse per 6 cycles; extra starts during busy ignored.
- Operands changed mid-SHIFT; then a second run with reset_n pulsed low 2 cycles after accept:
  - Operand change does not affect the result.
  - Reset clears outputs immediately; no done pulse; next start works normally.
- With SERIAL_SUB_OVF_EN: A=0111, B=1111, Bin=0 -> D=1000, Bout=1, ovf=1. A=0110, B=0001 -> ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor and its helpers.
package serial_sub_pkg;

    // Default operand width, matching the existing 4-bit datapath
    localparam int DEFAULT_WIDTH = 4;

    // Sequencing states of the serial subtractor
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
// Kept standalone so a ripple subtractor can reuse it later.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generated/propagated by this position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: D = A - B - Bin, LSB first, one bit per
// clock, with a start/busy/done handshake.
// Optional build macro SERIAL_SUB_OVF_EN adds a signed overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] r_sh;    // bits produced so far, filled from the MSB side
    logic [WIDTH-1:0] r_full;  // result register after this cycle's bit enters
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             borrow_next;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor_bit u_bit (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (d_bit),
        .bout (borrow_next)
    );

    // New difference bit enters at the top; after WIDTH shifts this is the result
    always_comb begin
        r_full = {d_bit, r_sh};
    end

    // Control FSM and serial datapath; D/Bout only change when the last bit lands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        borrow <= Bin;
                        r_sh   <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb  <= A[WIDTH-1];
                        b_msb  <= B[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= borrow_next;
                    r_sh   <= r_full[WIDTH-1:1];
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        D     <= r_full;
                        Bout  <= borrow_next;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // Operand signs differ and result sign flipped away from A
                        ovf   <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4).
// Build with SERIAL_SUB_OVF_EN defined to also exercise the ovf output.
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .Bin     (Bin),
        .busy    (busy),
        .done    (done),
        .D       (D),
        .Bout    (Bout)
`ifdef SERIAL_SUB_OVF_EN
       ,.ovf     (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted start at cycle c yields done during cycle
    // c+W and idle again at c+W+1; the result is plain integer arithmetic.
    int           cyc;
    int           acc;
    logic         m_busy, m_done, m_bout, p_bout;
    logic [W-1:0] m_d, p_d;
    logic         m_ovf, p_ovf;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0; acc = 0;
            m_busy = 0; m_done = 0; m_d = '0; m_bout = 0; m_ovf = 0;
            p_d = '0; p_bout = 0; p_ovf = 0;
        end else begin
            cyc++;
            if (m_busy && cyc == acc + W + 1) begin
                m_busy = 0;
                m_done = 0;
            end else if (m_busy && cyc == acc + W) begin
                m_done = 1;
                m_d    = p_d;
                m_bout = p_bout;
                m_ovf  = p_ovf;
            end else if (!m_busy && start) begin
                int diff, sdiff;
                m_busy = 1;
                acc    = cyc;
                diff   = int'(A) - int'(B) - int'(Bin);
                p_d    = W'(diff);
                p_bout = (diff < 0);
                sdiff  = int'($signed(A)) - int'($signed(B)) - int'(Bin);
                p_ovf  = (sdiff < -(2 ** (W - 1))) || (sdiff > (2 ** (W - 1)) - 1);
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", busy, m_busy);
            chk("cyc_done", done, m_done);
            chk("cyc_D",    D,    m_d);
            chk("cyc_Bout", Bout, m_bout);
`ifdef SERIAL_SUB_OVF_EN
            chk("cyc_ovf",  ovf,  m_ovf);
`endif
        end
    end

    // One operation; optionally scramble operands two cycles after accept
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input logic [W-1:0] ed, input logic eb, input bit chg);
        int lat;
        @(negedge clk);
        A = a; B = b; Bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (chg && lat == 3) begin
                A = ~a; B = ~b; Bin = ~bi;
            end
        end
        chk("latency", lat, W + 1);
        chk("lit_D", D, ed);
        chk("lit_Bout", Bout, eb);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        int ndone;
        int t_done[$];
        int wait_cnt;
        reset_n = 1'b0;
        start   = 1'b0;
        A = '0; B = '0; Bin = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en  = 1;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_D", D, 4'b0000);
        chk("rst_Bout", Bout, 1'b0);

        run_op(4'b0101, 4'b1010, 1'b0, 4'b1011, 1'b1, 0);
        run_op(4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 0);
        run_op(4'b0110, 4'b0001, 1'b0, 4'b0101, 1'b0, 0);

        // Operands scrambled mid-SHIFT: 9 - 3 - 1 = 5
        run_op(4'b1001, 4'b0011, 1'b1, 4'b0101, 1'b0, 1);

        // Reset asserted two cycles after accept
        @(negedge clk);
        A = 4'b0011; B = 4'b0001; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_D", D, 4'b0000);
        chk("midrst_Bout", Bout, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);

        // start held high: one done every W+2 cycles, results all 0000/1
        @(negedge clk);
        A = 4'b0000; B = 4'b1111; Bin = 1'b1; start = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            @(negedge clk);
            if (done) begin
                t_done.push_back(i);
                chk("hold_D", D, 4'b0000);
                chk("hold_Bout", Bout, 1'b1);
            end
        end
        start = 1'b0;
        chk("hold_pulses", t_done.size(), 4);
        if (t_done.size() > 0) chk("hold_first", t_done[0], W + 1);
        for (int i = 1; i < t_done.size(); i++)
            chk("hold_period", t_done[i] - t_done[i-1], W + 2);
        wait_cnt = 0;
        while (busy && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("hold_drain", busy, 1'b0);

        run_op(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 0);

`ifdef SERIAL_SUB_OVF_EN
        run_op(4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 0);
        chk("lit_ovf_set", ovf, 1'b1);
        run_op(4'b0110, 4'b0001, 1'b0, 4'b0101, 1'b0, 0);
        chk("lit_ovf_clr", ovf, 1'b0);
`endif

        repeat (2) @(negedge clk);
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
